// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: samples `in` once per divider tick, reports match progress,
// pulses `match` on each complete pattern and drives two 7-segment displays.
module seq_detect_fsm #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               DIV     = 25000000,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    input  logic             load_en,
    input  logic [PAT_W-1:0] pat_in,
    output logic             tick,
    output logic             match,
    output logic [3:0]       progress,
    output logic [CNT_W-1:0] match_cnt,
    output logic [6:0]       o1,
    output logic [6:0]       o2
);

    localparam int               DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [3:0]       PW    = 4'(PAT_W);
    localparam logic [PAT_W-1:0] ONES  = '1;

    logic [DIV_W-1:0] div_q,   div_d;
    logic [PAT_W-1:0] hist_q,  hist_d;
    logic [PAT_W-1:0] pat_q,   pat_d;
    logic [3:0]       vcnt_q,  vcnt_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign tick = en && (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q   <= '0;
            hist_q  <= '0;
            pat_q   <= PATTERN;
            vcnt_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            div_q   <= div_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            vcnt_q  <= vcnt_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        div_d   = div_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        vcnt_d  = vcnt_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        if (en) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        // A load drops any coincident sample; the divider above still advances.
        if (load_en) begin
            pat_d  = pat_in;
            hist_d = '0;
            vcnt_d = '0;
        end else if (tick) begin
            hist_d = {hist_q[PAT_W-2:0], in};
            vcnt_d = (vcnt_q == PW) ? PW : vcnt_q + 4'd1;
            if (vcnt_d == PW && hist_d == pat_q) begin
                match_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!OVERLAP) begin
                    vcnt_d = '0;
                end
            end
        end
    end

    // Longest prefix of the pattern that ends the valid part of the history.
    always_comb begin
        progress = '0;
        for (int unsigned k = 1; k <= PAT_W; k++) begin
            if (4'(k) <= vcnt_q &&
                ((hist_q ^ (pat_q >> (PAT_W - k))) & (ONES >> (PAT_W - k))) == '0) begin
                progress = 4'(k);
            end
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign o1        = seg7(progress);
    assign o2        = seg7(4'(cnt_q));

endmodule

// File: doc/seq_detect_fsm.md
Name: seq_detect_fsm

Overview:
Parametrised Mealy-style serial pattern detector, successor to the lab 4-state FSM with divided-clock stepping.
- Samples a 1-bit input once per internal divider tick.
- Tracks how much of a PAT_W-bit pattern has been matched and pulses on each complete match.
- Pattern is run-time loadable; overlap mode is selectable; matches are counted (saturating).
- Progress and match count drive two on-board 7-segment displays.

Parameters:
PAT_W, 4, pattern length in bits (2..15).
PATTERN, 4'b1011, reset pattern, MSB is the first bit expected.
DIV, 25000000, clock cycles per sample tick (1 = sample every cycle).
OVERLAP, 1, 1 = matches may share bits, 0 = history restarts after each match.
CNT_W, 8, match counter width.

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous active-low reset
in  in  1  serial data bit
en  in  1  divider run enable; 0 freezes the divider, so no ticks occur
load_en  in  1  load pat_in as the new pattern
pat_in  in  PAT_W  pattern to load
tick  out  1  sample strobe, combinational: (div_cnt==DIV-1) && en
match  out  1  registered, high for exactly one clk after a matching sample
progress  out  4  number of pattern bits currently matched (0..PAT_W)
match_cnt  out  CNT_W  saturating number of matches
o1  out  7  7-segment code of progress
o2  out  7  7-segment code of match_cnt[3:0]

Behaviour:
- Reset: all state updates on the clk edge where rst==0.
  - div_cnt=0, hist=0, vcnt=0, match=0, match_cnt=0.
  - Pattern register = PATTERN; any previously loaded pattern is discarded.
  - progress=0; o1 and o2 show digit 0.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps to 0 on the edge where tick==1.
  - When en==0, div_cnt holds its value.
  - DIV==1 means tick==en on every cycle.
- Sample (edge with tick==1, load_en==0):
  - hist <= {hist[PAT_W-2:0], in}.
  - vcnt <= min(vcnt+1, PAT_W).
  - Match condition: new vcnt==PAT_W and new hist==pattern.
  - On match: match<=1; match_cnt increments, holding at 2^CNT_W-1.
  - On match with OVERLAP==0: vcnt<=0, and the shift into hist still occurs.
  - Without a match: match<=0.
- match is also 0 on every edge without a sample, so it is a single-cycle pulse.
- progress (combinational): largest k ≤ vcnt such that hist[k-1:0] == pattern[PAT_W-1:PAT_W-k]; 0 if no such k.
  - Equals PAT_W while a match is held (OVERLAP==1).
  - Equals 0 after a match with OVERLAP==0.
- Load (edge with load_en==1):
  - pattern<=pat_in; hist<=0; vcnt<=0; match<=0.
  - match_cnt and div_cnt are unaffected.
  - Load wins over a simultaneous tick; that sample is dropped, but the divider still wraps.
- Reset wins over load and over a tick.
- 7-segment encoding:
  - Active-low segments, bit order {g,f,e,d,c,b,a}.
  - Hex digits 0-F; 0 = 7'b1000000, 1 = 7'b1111001.
  - Outputs are combinational from progress and match_cnt.
- in is sampled as-is; synchronisation of in is the caller's responsibility.

Test Plan:
1. Hold rst=0 for 2 clk, then release -> match=0, match_cnt=0, progress=0, o1=o2=7'b1000000. Check div_cnt: with DIV=4, tick on every 4th clk.
2. DIV=4, OVERLAP=1, PATTERN=1011, stream 1,0,1,1,0,1,1 (one bit per tick) -> progress after each sample 1,2,3,4,2,3,4; match pulses one cycle after samples 4 and 7; match_cnt=2.
3. Same stream with OVERLAP=0 -> progress 1,2,3,0,0,1,1; single match after sample 4; match_cnt=1.
4. Mid-stream, assert load_en with pat_in=0110 on the same edge as a tick -> that sample is ignored and progress=0. Then stream 0,1,1,0 -> match after the 4th sample.
5. CNT_W=2, drive 5 matches -> match_cnt goes 1,2,3,3,3; o2 shows 3 (7'b0110000).
6. With progress=3 and a loaded pattern 0110, pull rst=0 for 1 clk -> all state cleared and pattern back to 1011. en=0 for 10 clk -> no ticks and progress unchanged.
